// File: rtl/vdc_vram_arbiter.sv
// VRAM port arbiter for the VDC: display > CPU > DMA, with an aging counter
// that lets a starved DMA jump ahead of the CPU, and tagged read returns.
module vdc_vram_arbiter #(
    parameter int DMA_AGE_MAX = 8,
    parameter int AGE_W       = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        disp_req,
    input  logic [15:0] disp_addr,
    output logic        disp_gnt,
    output logic        disp_rvalid,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic        cpu_busy,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [15:0] rdata,
    output logic [15:0] MA,
    output logic        vram_we,
    output logic [15:0] MD_in,
    input  logic [15:0] MD_out
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_CPU  = 2'd2,
        TAG_DMA  = 2'd3
    } tag_t;

    localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(DMA_AGE_MAX);

    tag_t             tag;
    tag_t             tag_next;
    logic [AGE_W-1:0] age;
    logic             dma_promote;

    // Grants are held low while reset is asserted so the bus stays quiet.
    always_comb begin
        disp_gnt    = 1'b0;
        cpu_gnt     = 1'b0;
        dma_gnt     = 1'b0;
        dma_promote = dma_req && (age == AGE_LIMIT);
        if (!reset) begin
            if (disp_req)
                disp_gnt = 1'b1;
            else if (dma_promote)
                dma_gnt = 1'b1;
            else if (cpu_req)
                cpu_gnt = 1'b1;
            else if (dma_req)
                dma_gnt = 1'b1;
        end
    end

    assign cpu_busy = cpu_req && !cpu_gnt;

    always_comb begin
        MA       = 16'h0000;
        vram_we  = 1'b0;
        MD_in    = 16'h0000;
        tag_next = TAG_NONE;
        if (disp_gnt) begin
            MA       = disp_addr;
            tag_next = TAG_DISP;
        end else if (cpu_gnt) begin
            MA       = cpu_addr;
            vram_we  = cpu_we;
            MD_in    = cpu_wdata;
            tag_next = cpu_we ? TAG_NONE : TAG_CPU;
        end else if (dma_gnt) begin
            MA       = dma_addr;
            vram_we  = dma_we;
            MD_in    = dma_wdata;
            tag_next = dma_we ? TAG_NONE : TAG_DMA;
        end
    end

    // Only CPU wins charge the DMA; display-won cycles leave the count alone.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag <= TAG_NONE;
            age <= '0;
        end else begin
            tag <= tag_next;
            if (dma_gnt || !dma_req)
                age <= '0;
            else if (cpu_gnt && (age != AGE_LIMIT))
                age <= age + AGE_W'(1);
        end
    end

    assign disp_rvalid = (tag == TAG_DISP);
    assign cpu_rvalid  = (tag == TAG_CPU);
    assign dma_rvalid  = (tag == TAG_DMA);
    assign rdata       = (tag != TAG_NONE) ? MD_out : 16'h0000;

endmodule
